// File: rtl/ext_vector_sequencer.sv
// ---------------------------------------------------------------------------
// ExtVectorSequencer (top module ext_vector_sequencer)
//
// Purpose:
//   Upstream stimulus/check stage for black-box ext-module DUTs. Holds a
//   loadable table of (stimulus, expected) vectors. Each vector is driven
//   onto dut_foo, the block waits LAT cycles, then compares dut_bar against
//   the expected value. Reports done / pass / saturating error count to the
//   top-level tester, which owns $finish/$fatal.
//
// Parameters:
//   WIDTH  data width of the DUT foo/bar ports
//   DEPTH  vector table entries (power of two, >= 2)
//   LAT    cycles between stimulus register update and the bar sample (0..15)
//   ERR_W  width of the saturating mismatch counter
//
// Ports:
//   clock      in   single clock, all state updates on posedge
//   reset      in   synchronous, active-high
//   ld_valid   in   write one table entry (accepted in IDLE/DONE only)
//   ld_addr    in   table index to write
//   ld_stim    in   stimulus value for that entry
//   ld_exp     in   expected DUT response for that entry
//   num_vec    in   vectors to run, sampled on start, clamped to DEPTH
//   start      in   begin a run (accepted in IDLE/DONE only)
//   dut_foo    out  registered stimulus to the DUT
//   dut_bar    in   DUT response
//   busy       out  high in DRIVE, WAIT, CHECK
//   done       out  high in DONE
//   pass       out  done and no mismatches
//   err_count  out  mismatches this run, saturating at all-ones
//   vec_idx    out  index of the current vector
//
// Configuration:
//   SEQ_PRINTF_EN  when defined (and SYNTHESIS undefined), each CHECK
//                  mismatch prints a failure message.
// ---------------------------------------------------------------------------
module ext_vector_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int LAT   = 0,
  parameter int ERR_W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ld_valid,
  input  logic [$clog2(DEPTH)-1:0]   ld_addr,
  input  logic [WIDTH-1:0]           ld_stim,
  input  logic [WIDTH-1:0]           ld_exp,
  input  logic [$clog2(DEPTH+1)-1:0] num_vec,
  input  logic                       start,
  output logic [WIDTH-1:0]           dut_foo,
  input  logic [WIDTH-1:0]           dut_bar,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [ERR_W-1:0]           err_count,
  output logic [$clog2(DEPTH)-1:0]   vec_idx
);

  localparam int IW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);
  localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);
  // WAIT counts down from LAT-1 to 0, giving exactly LAT cycles in WAIT.
  localparam logic [3:0] WAIT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0] r_stimMem [DEPTH];
  logic [WIDTH-1:0] r_expMem  [DEPTH];

  logic [WIDTH-1:0] r_dutFoo;
  logic [ERR_W-1:0] r_errCount;
  logic [IW-1:0]    r_vecIdx;
  logic [NW-1:0]    r_numVec;
  logic [3:0]       r_waitCnt;

  logic             w_canAccept;
  logic             w_startRun;
  logic             w_lastVec;
  logic             w_mismatch;
  logic [NW-1:0]    w_numClamped;

  // Table writes and new runs are only accepted while no run is in flight.
  assign w_canAccept  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_startRun   = start && w_canAccept;
  assign w_numClamped = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
  assign w_lastVec    = (NW'(r_vecIdx) + NW'(1)) >= r_numVec;
  assign w_mismatch   = (dut_bar != r_expMem[r_vecIdx]);

  // Vector table; contents deliberately survive reset so a tester can
  // load once and rerun after an aborted run.
  always_ff @(posedge clock) begin
    if (ld_valid && w_canAccept) begin
      r_stimMem[ld_addr] <= ld_stim;
      r_expMem[ld_addr]  <= ld_exp;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A zero-length run skips straight to DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_nextState = (w_numClamped == '0) ? S_DONE : S_DRIVE;
        end
      end
      S_DRIVE: w_nextState = (LAT == 0) ? S_CHECK : S_WAIT;
      S_WAIT: begin
        if (r_waitCnt == 4'd0) begin
          w_nextState = S_CHECK;
        end
      end
      S_CHECK: w_nextState = w_lastVec ? S_DONE : S_DRIVE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath: run setup on start, stimulus drive, latency count and
  // result accumulation. dut_foo holds its last value outside DRIVE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dutFoo   <= '0;
      r_errCount <= '0;
      r_vecIdx   <= '0;
      r_numVec   <= '0;
      r_waitCnt  <= '0;
    end else begin
      if (w_startRun) begin
        r_numVec   <= w_numClamped;
        r_vecIdx   <= '0;
        r_errCount <= '0;
      end
      case (r_state)
        S_DRIVE: begin
          r_dutFoo  <= r_stimMem[r_vecIdx];
          r_waitCnt <= WAIT_LOAD;
        end
        S_WAIT: begin
          r_waitCnt <= r_waitCnt - 4'd1;
        end
        S_CHECK: begin
          if (w_mismatch && (r_errCount != '1)) begin
            r_errCount <= r_errCount + ERR_W'(1);
          end
          if (!w_lastVec) begin
            r_vecIdx <= r_vecIdx + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dut_foo   = r_dutFoo;
  assign err_count = r_errCount;
  assign vec_idx   = r_vecIdx;
  assign busy      = (r_state == S_DRIVE) || (r_state == S_WAIT) || (r_state == S_CHECK);
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && (r_errCount == '0);

`ifdef SEQ_PRINTF_EN
`ifndef SYNTHESIS
  // Simulation-only mismatch report; the top level decides
  // whether and when to stop the simulation.
  always @(posedge clock) begin
    if (!reset && (r_state == S_CHECK) && w_mismatch) begin
      $display("Assertion failed\nTest Failed!\nvec_idx=%0d dut_bar=0x%h expected=0x%h",
               r_vecIdx, dut_bar, r_expMem[r_vecIdx]);
    end
  end
`endif
`else
  // Mismatch reporting disabled: no simulation system tasks in this build.
`endif

endmodule

// File: tb/tb_ext_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ext_vector_sequencer
//
// Two sequencer instances share the load/start inputs: one with LAT=0 and
// an 8-bit error counter driving a combinational DUT model, one with LAT=3
// and a 2-bit error counter driving a 3-stage delayed DUT model. Both DUT
// models compute bar = foo + addK (addK=0 plain pass-through, addK=1 adder).
// Expected timing, stimulus sequence and error counts come from a table
// model and the run-length arithmetic of the sequencer's contract.
// ---------------------------------------------------------------------------
module tb_ext_vector_sequencer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int LAT1  = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] ld_stim;
  logic [15:0] ld_exp;
  logic [3:0]  num_vec;
  logic        start;

  logic [15:0] foo0, bar0, foo1, bar1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [7:0]  err0;
  logic [1:0]  err1;
  logic [2:0]  idx0, idx1;

  logic [15:0] addK;
  logic [15:0] pipe1, pipe2, pipe3;

  int checks = 0;
  int errors = 0;

  logic [15:0] refStim [DEPTH];
  logic [15:0] refExp  [DEPTH];
  logic [15:0] prevFoo [2];

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Zero-latency DUT model for the LAT=0 instance.
  assign bar0 = foo0 + addK;

  // Three-stage delayed DUT model for the LAT=3 instance.
  always @(posedge clock) begin
    pipe1 <= foo1 + addK;
    pipe2 <= pipe1;
    pipe3 <= pipe2;
  end
  assign bar1 = pipe3;

  ext_vector_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT(0), .ERR_W(8)) u0 (
    .clock(clock), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_stim(ld_stim), .ld_exp(ld_exp), .num_vec(num_vec), .start(start),
    .dut_foo(foo0), .dut_bar(bar0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .vec_idx(idx0)
  );

  ext_vector_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT(LAT1), .ERR_W(2)) u1 (
    .clock(clock), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_stim(ld_stim), .ld_exp(ld_exp), .num_vec(num_vec), .start(start),
    .dut_foo(foo1), .dut_bar(bar1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .vec_idx(idx1)
  );

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Write one table entry while idle and mirror it into the model.
  task automatic applyStimulus(input logic [2:0] addr, input logic [15:0] stim,
                               input logic [15:0] expv);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_stim  = stim;
    ld_exp   = expv;
    refStim[addr] = stim;
    refExp[addr]  = expv;
    tick();
    ld_valid = 1'b0;
  endtask

  // Both instances must show the post-reset state.
  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " foo0"}, 32'(foo0), 0);
    checkOutput({tag, " err0"}, 32'(err0), 0);
    checkOutput({tag, " idx0"}, 32'(idx0), 0);
    checkOutput({tag, " flags0"}, {29'd0, busy0, done0, pass0}, 0);
    checkOutput({tag, " foo1"}, 32'(foo1), 0);
    checkOutput({tag, " err1"}, 32'(err1), 0);
    checkOutput({tag, " idx1"}, 32'(idx1), 0);
    checkOutput({tag, " flags1"}, {29'd0, busy1, done1, pass1}, 0);
  endtask

  // Compare one instance against the model at cycle t after start.
  // A vector takes p cycles; vector k is visible on foo from cycle 2+k*p.
  task automatic checkInstance(input int inst, input int t, input int p,
                               input int nEff, input int expErr);
    logic [15:0] fooV;
    logic        busyV, doneV, passV;
    logic [7:0]  errV;
    logic [2:0]  idxV;
    string       pre;
    if (inst == 0) begin
      fooV = foo0; busyV = busy0; doneV = done0; passV = pass0; errV = err0; idxV = idx0;
    end else begin
      fooV = foo1; busyV = busy1; doneV = done1; passV = pass1; errV = 8'(err1); idxV = idx1;
    end
    pre = $sformatf("u%0d t=%0d", inst, t);
    if (t <= p * nEff) begin
      checkOutput({pre, " busy"}, 32'(busyV), 1);
      checkOutput({pre, " done"}, 32'(doneV), 0);
      checkOutput({pre, " vec_idx"}, 32'(idxV), 32'((t - 1) / p));
      checkOutput({pre, " dut_foo"}, 32'(fooV),
                  32'((t >= 2) ? refStim[(t - 2) / p] : prevFoo[inst]));
    end else begin
      checkOutput({pre, " busy"}, 32'(busyV), 0);
      checkOutput({pre, " done"}, 32'(doneV), 1);
      checkOutput({pre, " err_count"}, 32'(errV), 32'(expErr));
      checkOutput({pre, " pass"}, 32'(passV), 32'(expErr == 0));
      checkOutput({pre, " dut_foo"}, 32'(fooV),
                  32'((nEff > 0) ? refStim[nEff - 1] : prevFoo[inst]));
    end
  endtask

  // Start a run of n vectors and follow both instances cycle by cycle
  // until one cycle past the slower instance's done. Optionally poke
  // ld/start while busy, or assert reset at cycle resetAt.
  task automatic runVectors(input int n, input bit withIgnored, input int resetAt);
    int nEff, mis, e0, e1, tEnd;
    nEff = (n > DEPTH) ? DEPTH : n;
    mis = 0;
    for (int i = 0; i < nEff; i++) begin
      if (refExp[i] != 16'(refStim[i] + addK)) mis++;
    end
    e0 = (mis > 255) ? 255 : mis;
    e1 = (mis > 3) ? 3 : mis;
    tEnd = (2 + LAT1) * nEff + 1;
    start   = 1'b1;
    num_vec = 4'(n);
    tick();
    start    = 1'b0;
    ld_valid = 1'b0;
    num_vec  = 4'($urandom_range(15, 0));
    for (int t = 1; t <= tEnd + 1; t++) begin
      checkInstance(0, t, 2, nEff, e0);
      checkInstance(1, t, 2 + LAT1, nEff, e1);
      if (withIgnored && t == 1) begin
        ld_valid = 1'b1;
        ld_addr  = 3'(nEff - 1);
        ld_stim  = ~refStim[nEff - 1];
        ld_exp   = ~refExp[nEff - 1];
        start    = 1'b1;
        num_vec  = 4'd1;
      end else if (withIgnored && t == 2) begin
        ld_valid = 1'b0;
        start    = 1'b0;
      end
      if (t == resetAt) begin
        reset = 1'b1;
        tick();
        checkIdleZero($sformatf("reset at t=%0d", t));
        reset = 1'b0;
        prevFoo[0] = '0;
        prevFoo[1] = '0;
        return;
      end
      tick();
    end
    if (nEff > 0) begin
      prevFoo[0] = refStim[nEff - 1];
      prevFoo[1] = refStim[nEff - 1];
    end
  endtask

  // Main sequence: reset, directed scenarios, randomized runs.
  initial begin
    logic [15:0] s;
    reset    = 1'b1;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_stim  = '0;
    ld_exp   = '0;
    num_vec  = '0;
    start    = 1'b0;
    addK     = 16'd0;
    prevFoo[0] = '0;
    prevFoo[1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      refStim[i] = '0;
      refExp[i]  = '0;
    end
    tick();
    tick();
    checkIdleZero("reset");
    reset = 1'b0;
    tick();
    checkIdleZero("idle after reset");

    $display("[TB] pass path with two vectors");
    applyStimulus(3'd0, 16'h04D2, 16'h04D2);
    applyStimulus(3'd1, 16'h162E, 16'h162E);
    runVectors(2, 1'b0, 0);

    $display("[TB] adder pass then reload expected value with start");
    addK = 16'd1;
    applyStimulus(3'd0, 16'h0064, 16'h0065);
    runVectors(1, 1'b0, 0);
    ld_valid = 1'b1;
    ld_addr  = 3'd0;
    ld_stim  = 16'h0064;
    ld_exp   = 16'h0064;
    refExp[0] = 16'h0064;
    runVectors(1, 1'b0, 0);

    $display("[TB] all eight vectors mismatch");
    for (int i = 0; i < DEPTH; i++) begin
      s = 16'($urandom);
      applyStimulus(3'(i), s, 16'(s + addK + 16'd1));
    end
    runVectors(8, 1'b0, 0);

    $display("[TB] zero-length run");
    runVectors(0, 1'b0, 0);

    $display("[TB] ignored load/start while busy, num_vec clamp");
    addK = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      s = 16'($urandom);
      applyStimulus(3'(i), s, s);
    end
    runVectors(15, 1'b1, 0);
    runVectors(8, 1'b0, 0);

    $display("[TB] reset during WAIT of vector 2, then rerun");
    runVectors(4, 1'b0, 12);
    runVectors(4, 1'b0, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      addK = 16'($urandom_range(1, 0));
      for (int i = 0; i < DEPTH; i++) begin
        s = 16'($urandom);
        applyStimulus(3'(i), s, ($urandom_range(2, 0) == 0) ? 16'($urandom) : 16'(s + addK));
      end
      runVectors(int'($urandom_range(15, 0)), 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
